multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences a multicycle RV32I-subset datapath: the shared ALU/adder, a unified instruction/data memory with a ready handshake, and the register file. It supports lw, sw, R-type, I-type ALU, beq and jal. It drives every mux select and write enable, and it traps into a sticky FAULT state on an illegal opcode or funct, or on a memory timeout.

Parameters:
MEM_TIMEOUT  255  maximum wait cycles for MemReady in any memory state before FAULT (1..255)
CNT_W        8    width of the memory-wait counter

Ports:
clk         in   1  clock, all state updates on the rising edge
reset       in   1  asynchronous, active-low reset (0 = reset)
op          in   7  instruction opcode, Instr[6:0] from the instruction register
funct3      in   3  Instr[14:12]
funct7b5    in   1  Instr[30]
Zero        in   1  ALU zero flag
MemReady    in   1  memory completes the current access this cycle
MemReq      out  1  memory access request
AdrSrc      out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite    out  1  memory write strobe
IRWrite     out  1  instruction register and OldPC load
PCWrite     out  1  PC load
RegWrite    out  1  register file write
ResultSrc   out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA     out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB     out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = const 4
ImmSrc      out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
Fault       out  1  sticky error flag
State       out  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, FAULT=15.
- While reset=0 (asynchronous):
  - state=FETCH, wait counter=0, Fault=0.
  - MemReq, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0.
  - All other outputs are 0.
- First rising edge after reset release: FETCH outputs are active.
- ImmSrc is combinational from op in every state:
  - 0000011 / 0010011 → 00
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise → 00
- Unlisted outputs in each state are 0.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, add (computes the branch/jump target into ALUOut).
  - Next state by op: lw/sw → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BEQ; 1101111 → JAL; any other op → FAULT.
  - Illegal function codes also go to FAULT:
    - R-type funct3 not in {000, 010, 110, 111}.
    - I-type funct3 not in {000, 010, 110, 111}.
    - beq funct3 ≠ 000.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, add.
  - Next state: op=lw → MEMREAD, otherwise MEMWRITE.
- MEMREAD:
  - Outputs: MemReq=1, AdrSrc=1, ResultSrc=00.
  - On MemReady → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then → FETCH.
- MEMWRITE:
  - Outputs: MemReq=1, AdrSrc=1, ResultSrc=00.
  - MemWrite=1 while waiting.
  - On MemReady → FETCH.
- EXECUTER:
  - Outputs: ALUSrcA=10, ALUSrcB=00.
  - ALUControl by funct3: 000 → sub if funct7b5=1, else add; 010 → slt; 110 → or; 111 → and.
  - Next state: ALUWB.
- EXECUTEI:
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - ALUControl by the same funct3 map, except 000 is always add (funct7b5 ignored).
  - Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then → FETCH.
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = Zero (combinational).
  - Next state: FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - Next state: ALUWB, which writes PC+4 to rd.
- FAULT:
  - Fault=1 and all write enables and MemReq are 0.
  - The FSM stays in FAULT until reset.
- Wait counter:
  - Increments on each cycle spent in FETCH, MEMREAD or MEMWRITE with MemReady=0.
  - Clears on any state change.
  - If the counter equals MEM_TIMEOUT while MemReady=0, the next state is FAULT.
  - MemReady=1 in the same cycle the counter reaches the limit wins: the access completes normally.
- Reset asserted mid-instruction aborts immediately; no partial write enable may remain asserted.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1 always → State sequence 0,1,6,8,0; ALUControl=000 in EXECUTER; RegWrite=1 only in cycle 4.
- sub (f7b5=1) → ALUControl=001 in EXECUTER; addi with Instr[30]=1 → ALUControl=000 in EXECUTEI.
- lw with MemReady low for 3 cycles in MEMREAD → State holds at 3 for 4 cycles; MEMWB follows with ResultSrc=01 and RegWrite=1 for exactly 1 cycle.
- beq, once with Zero=1 and once with Zero=0 → PCWrite=1 and PCWrite=0 respectively in the BEQ cycle; ALUControl=001; next state FETCH.
- op=0000000 → DECODE→FAULT; Fault=1 stays high for 20 cycles; reset low then high → State=0, Fault=0.
- MEM_TIMEOUT=4 with MemReady held 0 in FETCH → FAULT after 5 FETCH cycles. Reset pulsed mid-MEMWRITE → MemWrite drops in the same cycle as the reset assertion.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for a multicycle RV32I-subset datapath (lw, sw, R-type,
// I-type ALU, beq, jal). It drives the datapath mux selects and write
// enables. It traps into a sticky FAULT state on an illegal opcode or funct3,
// or when memory does not answer within MEM_TIMEOUT wait cycles.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   op           Instr[6:0]
//   funct3       Instr[14:12]
//   funct7b5     Instr[30]
//   Zero         ALU zero flag
//   MemReady     memory completes the current access this cycle
//   MemReq       memory access request
//   AdrSrc       memory address select (0 PC, 1 ALUOut)
//   MemWrite     memory write strobe
//   IRWrite      IR / OldPC load
//   PCWrite      PC load
//   RegWrite     register file write
//   ResultSrc    00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA      00 PC, 01 OldPC, 10 rs1
//   ALUSrcB      00 rs2, 01 ImmExt, 10 const 4
//   ImmSrc       00 I, 01 S, 10 B, 11 J (decoded from op in every state)
//   ALUControl   000 add, 001 sub, 010 and, 011 or, 101 slt
//   Fault        sticky error flag
//   State        current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Fault,
  output logic [3:0] State
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_FAULT    = 4'd15;

  // Opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Mux select encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Ungated output values, qualified by reset below
  logic       mem_req_c, adr_src_c, mem_write_c, ir_write_c, pc_write_c;
  logic       reg_write_c, fault_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
  logic [2:0] alu_control_c;

  logic legal_f3;
  logic mem_wait;

  // funct3 -> ALU operation; sub_ok selects sub for funct3=000
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
    logic [2:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = sub_ok ? ALU_SUB : ALU_ADD;
      3'b010:  r = ALU_SLT;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // funct3 values supported by R-type and I-type ALU ops
  assign legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);

  // States that wait on the memory handshake
  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    mem_req_c     = 1'b0;
    adr_src_c     = 1'b0;
    mem_write_c   = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    fault_c       = 1'b0;
    result_src_c  = RES_ALUOUT;
    alu_src_a_c   = SRCA_PC;
    alu_src_b_c   = SRCB_RS2;
    alu_control_c = ALU_ADD;

    // Immediate format follows op in every state
    case (op)
      OP_LW, OP_I: imm_src_c = IMM_I;
      OP_SW:       imm_src_c = IMM_S;
      OP_BEQ:      imm_src_c = IMM_B;
      OP_JAL:      imm_src_c = IMM_J;
      default:     imm_src_c = IMM_I;
    endcase

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        adr_src_c    = 1'b0;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURES;
        ir_write_c   = MemReady;
        pc_write_c   = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch / jump target lands in ALUOut
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = legal_f3 ? S_EXECUTER : S_FAULT;
          OP_I:         state_d = legal_f3 ? S_EXECUTEI : S_FAULT;
          OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_FAULT;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_RS2;
        alu_control_c = alu_dec(funct3, funct7b5);
        state_d       = S_ALUWB;
      end
      S_EXECUTEI: begin
        // Instr[30] is part of the immediate here, never a sub select
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_IMM;
        alu_control_c = alu_dec(funct3, 1'b0);
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c   = SRCA_RS1;
        alu_src_b_c   = SRCB_RS2;
        alu_control_c = ALU_SUB;
        pc_write_c    = Zero;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        // PC <- target (ALUOut); ALU computes OldPC+4 for the link write
        alu_src_a_c   = SRCA_OLDPC;
        alu_src_b_c   = SRCB_FOUR;
        pc_write_c    = 1'b1;
        state_d       = S_ALUWB;
      end
      S_FAULT: begin
        fault_c = 1'b1;
        state_d = S_FAULT;
      end
      default: begin
        fault_c = 1'b1;
        state_d = S_FAULT;
      end
    endcase

    // Memory wait timeout; a ready on the limit cycle still completes
    if (mem_wait && !MemReady) begin
      if (cnt_q == CNT_LIMIT) begin
        state_d = S_FAULT;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reset forces every output low, so an aborted access drops at once
  assign MemReq     = reset & mem_req_c;
  assign AdrSrc     = reset & adr_src_c;
  assign MemWrite   = reset & mem_write_c;
  assign IRWrite    = reset & ir_write_c;
  assign PCWrite    = reset & pc_write_c;
  assign RegWrite   = reset & reg_write_c;
  assign Fault      = reset & fault_c;
  assign ResultSrc  = reset ? result_src_c  : 2'b00;
  assign ALUSrcA    = reset ? alu_src_a_c   : 2'b00;
  assign ALUSrcB    = reset ? alu_src_b_c   : 2'b00;
  assign ImmSrc     = reset ? imm_src_c     : 2'b00;
  assign ALUControl = reset ? alu_control_c : 3'b000;
  assign State      = state_q;

endmodule
